// File: rtl/arbitro_bus_rtc.sv
// Bus arbiter sharing the RTC bus-cycle engine between the read and write sequencers.
// Define ARB_PRIO_ESCRITURA_EN for fixed write priority instead of round robin.
module arbitro_bus_rtc #(
    parameter int REFRESH_CYC = 100000,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_L,
    input  logic       req_E,
    input  logic [4:0] ctrl_L,
    input  logic [4:0] ctrl_E,
    input  logic       Final_WR,
    output logic       Inicio_L,
    output logic       gnt_L,
    output logic       gnt_E,
    output logic       Final_L,
    output logic       Final_E,
    output logic       Inicio_T,
    output logic [4:0] ctrl_bus,
    output logic       error_T,
    output logic       ocupado
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(REFRESH_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, CHECK} state_t;

    state_t        state;
    state_t        state_next;
    logic          gnt_l_next;
    logic          gnt_e_next;
    logic          load_ctrl;
    logic          win_l;
    logic          owner_req;
    logic          in_wait;
    logic          to_hit;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_pend;

`ifdef ARB_PRIO_ESCRITURA_EN
    assign win_l = req_L && !req_E;
`else
    // last_e remembers who was granted most recently; it starts at E so the first tie goes to L.
    logic last_e;
    assign win_l = req_L && (!req_E || last_e);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_e <= 1'b1;
        else if (state == IDLE && (req_L || req_E))
            last_e <= !win_l;
    end
`endif

    assign owner_req = gnt_L ? req_L : req_E;
    assign in_wait   = (state == WAIT);
    assign to_hit    = (to_cnt == TO_LAST);

    always_comb begin
        state_next = state;
        gnt_l_next = gnt_L;
        gnt_e_next = gnt_E;
        load_ctrl  = 1'b0;
        case (state)
            IDLE: begin
                if (req_L || req_E) begin
                    state_next = START;
                    gnt_l_next = win_l;
                    gnt_e_next = !win_l;
                    load_ctrl  = 1'b1;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                // A completion in the timeout cycle still counts as a normal completion.
                if (Final_WR) begin
                    state_next = CHECK;
                end else if (to_hit) begin
                    state_next = IDLE;
                    gnt_l_next = 1'b0;
                    gnt_e_next = 1'b0;
                end
            end
            CHECK: begin
                if (owner_req) begin
                    state_next = START;
                    load_ctrl  = 1'b1;
                end else begin
                    state_next = IDLE;
                    gnt_l_next = 1'b0;
                    gnt_e_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_L    <= 1'b0;
            gnt_E    <= 1'b0;
            ctrl_bus <= 5'b00000;
        end else begin
            state <= state_next;
            gnt_L <= gnt_l_next;
            gnt_E <= gnt_e_next;
            if (load_ctrl)
                ctrl_bus <= gnt_l_next ? ctrl_L : ctrl_E;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (state == START)
            to_cnt <= '0;
        else if (in_wait)
            to_cnt <= to_cnt + 1'b1;
    end

    // Free-running refresh timer; an expiry stays pending until the read side is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt  <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            ref_pend <= (ref_cnt == REF_LAST) || (ref_pend && !Inicio_L);
        end
    end

    assign Inicio_L = ref_pend && !gnt_L && !req_L;
    assign Inicio_T = (state == START);
    assign Final_L  = in_wait && Final_WR && gnt_L;
    assign Final_E  = in_wait && Final_WR && gnt_E;
    assign error_T  = in_wait && !Final_WR && to_hit;
    assign ocupado  = (state != IDLE);

endmodule

// File: tb/tb_arbitro_bus_rtc.sv
// Self-checking bench for arbitro_bus_rtc: directed scenarios plus randomized sweeps
// checked against a transaction-level model of grants, step codes and timing.
module tb_arbitro_bus_rtc;

    localparam int REF = 50;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_L = 1'b0;
    logic       req_E = 1'b0;
    logic [4:0] ctrl_L = 5'd0;
    logic [4:0] ctrl_E = 5'd0;
    logic       Final_WR = 1'b0;
    logic       Inicio_L;
    logic       gnt_L;
    logic       gnt_E;
    logic       Final_L;
    logic       Final_E;
    logic       Inicio_T;
    logic [4:0] ctrl_bus;
    logic       error_T;
    logic       ocupado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit last_e = 1'b1;
    bit chk_ref = 1'b0;

    arbitro_bus_rtc #(
        .REFRESH_CYC(REF),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_L(req_L),
        .req_E(req_E),
        .ctrl_L(ctrl_L),
        .ctrl_E(ctrl_E),
        .Final_WR(Final_WR),
        .Inicio_L(Inicio_L),
        .gnt_L(gnt_L),
        .gnt_E(gnt_E),
        .Final_L(Final_L),
        .Final_E(Final_E),
        .Inicio_T(Inicio_T),
        .ctrl_bus(ctrl_bus),
        .error_T(error_T),
        .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_inicio_l"}, Inicio_L, 1'b0);
        chk1({tag, "_gnt_l"}, gnt_L, 1'b0);
        chk1({tag, "_gnt_e"}, gnt_E, 1'b0);
        chk1({tag, "_final"}, Final_L | Final_E, 1'b0);
        chk1({tag, "_inicio_t"}, Inicio_T, 1'b0);
        chk1({tag, "_error"}, error_T, 1'b0);
        chk1({tag, "_ocupado"}, ocupado, 1'b0);
        chk5({tag, "_ctrl_bus"}, ctrl_bus, 5'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        req_L = 1'b0;
        req_E = 1'b0;
        Final_WR = 1'b0;
        ctrl_L = 5'd0;
        ctrl_E = 5'd0;
        #1;
        chk_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc = 0;
        last_e = 1'b1;
        chk_ref = 1'b0;
    endtask

    // Arbitration rule: lone requester wins; on a tie the side not granted last wins.
    function automatic bit pick_l(input bit rl, input bit re);
        if (rl && !re) return 1'b1;
        if (!rl) return 1'b0;
`ifdef ARB_PRIO_ESCRITURA_EN
        return 1'b0;
`else
        return last_e;
`endif
    endfunction

    // One full sweep by the expected owner, starting in an IDLE cycle.
    // Each step: START one cycle after IDLE/CHECK, Final after lat cycles, CHECK, then next START.
    task automatic sweep(input bit own_l, input int nsteps, input bit seq, input int lat_fix,
                         input int lat_max);
        logic [4:0] code;
        int lat;
        last_e = !own_l;
        for (int s = 0; s < nsteps; s++) begin
            code = seq ? 5'(s + 1) : 5'($urandom_range(0, 31));
            if (own_l) begin
                req_L = 1'b1;
                ctrl_L = code;
            end else begin
                req_E = 1'b1;
                ctrl_E = code;
            end
            tick();
            Final_WR = 1'b0;
            settle();
            chk1("start_pulse", Inicio_T, 1'b1);
            chk5("start_code", ctrl_bus, code);
            chk1("start_gnt_own", own_l ? gnt_L : gnt_E, 1'b1);
            chk1("start_gnt_other", own_l ? gnt_E : gnt_L, 1'b0);
            chk1("start_busy", ocupado, 1'b1);
            if (chk_ref) chk1("defer_start", Inicio_L, 1'b0);
            if (own_l) ctrl_L = ~code; else ctrl_E = ~code;
            if (lat_fix != 0) lat = lat_fix;
            else lat = int'($urandom_range(1, lat_max));
            for (int k = 1; k < lat; k++) begin
                tick();
                settle();
                chk1("wait_no_start", Inicio_T, 1'b0);
                chk1("wait_no_err", error_T, 1'b0);
                chk1("wait_final", Final_L | Final_E, 1'b0);
                chk5("wait_code_hold", ctrl_bus, code);
                chk1("wait_gnt_other", own_l ? gnt_E : gnt_L, 1'b0);
                if (chk_ref) chk1("defer_wait", Inicio_L, 1'b0);
            end
            tick();
            Final_WR = 1'b1;
            settle();
            chk1("final_own", own_l ? Final_L : Final_E, 1'b1);
            chk1("final_other", own_l ? Final_E : Final_L, 1'b0);
            chk1("final_no_err", error_T, 1'b0);
            chk1("final_no_start", Inicio_T, 1'b0);
            tick();
            Final_WR = 1'($urandom_range(0, 1));
            if (s == nsteps - 1) begin
                if (own_l) req_L = 1'b0; else req_E = 1'b0;
            end
            settle();
            chk1("check_final_masked", Final_L | Final_E, 1'b0);
            chk1("check_gnt_kept", own_l ? gnt_L : gnt_E, 1'b1);
            chk1("check_no_start", Inicio_T, 1'b0);
            chk1("check_busy", ocupado, 1'b1);
            if (chk_ref) chk1("defer_check", Inicio_L, 1'b0);
        end
        tick();
        Final_WR = 1'b0;
        settle();
        chk1("end_gnt", gnt_L | gnt_E, 1'b0);
        chk1("end_idle", ocupado, 1'b0);
        chk1("end_no_start", Inicio_T, 1'b0);
    endtask

    task automatic serve(input int maxsteps, input int lat_max);
        int guard;
        guard = 0;
        while ((req_L || req_E) && guard < 4) begin
            sweep(pick_l(req_L, req_E), int'($urandom_range(1, maxsteps)), 1'b0, 0, lat_max);
            guard++;
        end
        chk1("serve_drained", req_L | req_E, 1'b0);
    endtask

    initial begin
        do_reset("reset");

        // Refresh with no requests: pulses at 50, 100, 150.
        for (int c = 0; c < 160; c++) begin
            tick();
            settle();
            chk1("refresh_pulse", Inicio_L, (cyc % REF) == 0);
            chk1("refresh_idle", ocupado, 1'b0);
        end

        do_reset("reset_read");
        sweep(1'b1, 3, 1'b1, 4, TO);

        // Simultaneous requests, then a second tie.
        do_reset("reset_tie");
        req_L = 1'b1;
        req_E = 1'b1;
        serve(3, TO);
        req_L = 1'b1;
        req_E = 1'b1;
        serve(3, TO);

        // Engine timeout, regrant, then a completion landing exactly on the timeout cycle.
        do_reset("reset_to");
        req_E = 1'b1;
        ctrl_E = 5'h1A;
        last_e = 1'b1;
        tick(); settle();
        chk1("to_start", Inicio_T, 1'b1);
        chk1("to_gnt", gnt_E, 1'b1);
        chk5("to_code", ctrl_bus, 5'h1A);
        for (int k = 1; k < TO; k++) begin
            tick(); settle();
            chk1("to_no_err_early", error_T, 1'b0);
            chk1("to_gnt_held", gnt_E, 1'b1);
        end
        tick(); settle();
        chk1("to_error", error_T, 1'b1);
        chk1("to_no_final", Final_E, 1'b0);
        tick(); settle();
        chk1("to_error_one_cycle", error_T, 1'b0);
        chk1("to_gnt_drop", gnt_E, 1'b0);
        chk1("to_idle", ocupado, 1'b0);
        tick(); settle();
        chk1("to_restart", Inicio_T, 1'b1);
        chk1("to_regnt", gnt_E, 1'b1);
        for (int k = 1; k < TO; k++) begin
            tick(); settle();
            chk1("to2_no_err", error_T, 1'b0);
        end
        tick();
        Final_WR = 1'b1;
        settle();
        chk1("to_edge_final", Final_E, 1'b1);
        chk1("to_edge_no_err", error_T, 1'b0);
        tick();
        Final_WR = 1'b0;
        req_E = 1'b0;
        settle();
        chk1("to_edge_check", gnt_E, 1'b1);
        tick(); settle();
        chk1("to_edge_release", gnt_E, 1'b0);
        chk1("to_edge_idle", ocupado, 1'b0);

        // Refresh expiry at cycle 50 during a read sweep is deferred to the first free cycle.
        do_reset("reset_defer");
        for (int c = 0; c < 44; c++) begin
            tick(); settle();
            chk1("defer_pre", Inicio_L, 1'b0);
        end
        chk_ref = 1'b1;
        sweep(1'b1, 3, 1'b0, 0, 8);
        chk_ref = 1'b0;
        chk1("defer_pulse", Inicio_L, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(); settle();
            chk1("defer_single", Inicio_L, 1'b0);
        end

        // Asynchronous reset while L is waiting on the engine.
        do_reset("reset_async_pre");
        req_L = 1'b1;
        ctrl_L = 5'h07;
        last_e = 1'b0;
        tick(); settle();
        chk1("async_start", Inicio_T, 1'b1);
        tick(); settle();
        chk1("async_wait_gnt", gnt_L, 1'b1);
        chk5("async_wait_code", ctrl_bus, 5'h07);
        #1;
        reset = 1'b1;
        Final_WR = 1'b1;
        #1;
        chk_zero("async");
        do_reset("reset_async_hold");
        req_L = 1'b1;
        req_E = 1'b1;
        serve(2, TO);

        // Randomized request patterns with stray completions in IDLE.
        for (int it = 0; it < 12; it++) begin
            int r;
            r = int'($urandom_range(1, 3));
            req_L = r[0];
            req_E = r[1];
            Final_WR = 1'($urandom_range(0, 1));
            settle();
            chk1("idle_final_ignored", Final_L | Final_E, 1'b0);
            chk1("idle_not_busy", ocupado, 1'b0);
            serve(4, TO);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
